// File: rtl/signed_sat_accumulator.sv
// Packet accumulator: sums signed samples with per-addition saturation and holds one result for a valid/ready sink.
// Define SIGNED_SAT_ACC_CNT_EN to add the sat_events overflow counter output.
module signed_sat_accumulator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_sat
`ifdef SIGNED_SAT_ACC_CNT_EN
  ,
  output logic [15:0]      sat_events
`endif
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM_EMPTY = 1'b0,
    ACCUM_BUSY  = 1'b1
  } pkt_state_t;

  pkt_state_t       pkt_state;
  logic [WIDTH-1:0] acc;
  logic             sat_flag;

  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] sum_wrap;
  logic [WIDTH-1:0] sum_sat;
  logic             ovf;
  logic             beat_acc;
  logic             beat_last;

  // One-entry output register: refill allowed in the same cycle it drains.
  assign up_ready  = ~down_valid | down_ready;
  assign beat_acc  = up_valid & up_ready;
  assign beat_last = beat_acc & up_last;

  // Saturating add; a fresh packet always starts from zero.
  always_comb begin
    acc_base = '0;
    sum_wrap = '0;
    ovf      = 1'b0;
    sum_sat  = '0;
    if (pkt_state == ACCUM_BUSY) begin
      acc_base = acc;
    end
    sum_wrap = acc_base + up_data;
    ovf      = (acc_base[WIDTH-1] == up_data[WIDTH-1]) &&
               (sum_wrap[WIDTH-1] != acc_base[WIDTH-1]);
    if (ovf) begin
      sum_sat = acc_base[WIDTH-1] ? MIN_NEG : MAX_POS;
    end else begin
      sum_sat = sum_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state <= ACCUM_EMPTY;
      acc       <= '0;
      sat_flag  <= 1'b0;
    end else if (beat_acc) begin
      if (up_last) begin
        pkt_state <= ACCUM_EMPTY;
        acc       <= '0;
        sat_flag  <= 1'b0;
      end else begin
        pkt_state <= ACCUM_BUSY;
        acc       <= sum_sat;
        sat_flag  <= sat_flag | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_sat   <= 1'b0;
    end else if (beat_last) begin
      down_valid <= 1'b1;
      down_data  <= sum_sat;
      down_sat   <= sat_flag | ovf;
    end else if (down_valid && down_ready) begin
      down_valid <= 1'b0;
    end
  end

`ifdef SIGNED_SAT_ACC_CNT_EN
  // Sticky overflow event count, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_events <= '0;
    end else if (beat_acc && ovf && (sat_events != 16'hFFFF)) begin
      sat_events <= sat_events + 16'(1);
    end
  end
`endif

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Scoreboard bench for signed_sat_accumulator: directed cases plus randomized packets and backpressure.
module tb_signed_sat_accumulator;

  localparam int W    = 4;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] up_data;
  logic         up_last;
  logic         down_valid;
  logic         down_ready;
  logic [W-1:0] down_data;
  logic         down_sat;
`ifdef SIGNED_SAT_ACC_CNT_EN
  logic [15:0]  sat_events;
`endif

  signed_sat_accumulator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_sat   (down_sat)
`ifdef SIGNED_SAT_ACC_CNT_EN
    ,
    .sat_events (sat_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_acc = 0;
  bit   m_sat = 1'b0;
  int   m_cnt = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum clamped to the signed range after every addition.
  task automatic model_beat(input int d, input bit last);
    int s;
    bit o;
    s = m_acc + d;
    o = 1'b0;
    if (s > MAXV) begin s = MAXV; o = 1'b1; end
    if (s < MINV) begin s = MINV; o = 1'b1; end
    if (o && m_cnt < 65535) m_cnt++;
    if (last) begin
      q.push_back('{data: s, sat: m_sat | o});
      m_acc = 0;
      m_sat = 1'b0;
    end else begin
      m_acc = s;
      m_sat = m_sat | o;
    end
  endtask

  task automatic send_beat(input int d, input bit last);
    int n;
    n = 0;
    up_valid = 1'b1;
    up_data  = W'(d);
    up_last  = last;
    forever begin
      @(negedge clk);
      if (up_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        up_valid = 1'b0;
        return;
      end
    end
    model_beat(d, last);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_acc = 0;
    m_sat = 1'b0;
    m_cnt = 0;
    q.delete();
    @(negedge clk);
    check("reset_down_valid", int'(down_valid), 0);
    check("reset_down_data", int'(down_data), 0);
    check("reset_down_sat", int'(down_sat), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops an expectation on every output transfer and checks holding rules.
  logic [W-1:0] prev_data;
  logic         prev_sat;
  bit           prev_hold = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      check("up_ready_rule", int'(up_ready), int'(!down_valid || down_ready));
      if (prev_hold) begin
        check("hold_valid", int'(down_valid), 1);
        check("hold_data", int'(down_data), int'(prev_data));
        check("hold_sat", int'(down_sat), int'(prev_sat));
      end
      if (down_valid && down_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          check("down_data", int'($signed(down_data)), e.data);
          check("down_sat", int'(down_sat), int'(e.sat));
        end
      end
      prev_hold = down_valid && !down_ready;
      prev_data = down_data;
      prev_sat  = down_sat;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) down_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    int len;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_last    = 1'b0;
    down_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("init_down_valid", int'(down_valid), 0);
    check("init_down_data", int'(down_data), 0);
`ifdef SIGNED_SAT_ACC_CNT_EN
    check("init_sat_events", int'(sat_events), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Latency of one cycle after the last beat.
    send_beat(3, 1'b0);
    send_beat(4, 1'b1);
    @(negedge clk);
    check("latency_valid", int'(down_valid), 1);
    idle(2);

    // Mid-packet reset discards the partial sum.
    send_beat(6, 1'b0);
    send_beat(1, 1'b0);
    do_reset();
    send_beat(2, 1'b1);
    idle(2);
`ifdef SIGNED_SAT_ACC_CNT_EN
    check("sat_events_after_reset", int'(sat_events), 0);
`endif

    // Positive and negative saturation.
    send_beat(7, 1'b0);
    send_beat(1, 1'b1);
    send_beat(-8, 1'b0);
    send_beat(-1, 1'b1);
    idle(2);
`ifdef SIGNED_SAT_ACC_CNT_EN
    check("sat_events_two", int'(sat_events), m_cnt);
    check("sat_events_const", int'(sat_events), 2);
`endif

    // Clamp then continue; flag clears for the next packet.
    send_beat(7, 1'b0);
    send_beat(1, 1'b0);
    send_beat(-3, 1'b1);
    send_beat(2, 1'b1);
    idle(2);

    // Backpressure: result held, beats refused, then drain-and-refill.
    down_ready = 1'b0;
    send_beat(3, 1'b1);
    up_valid = 1'b1;
    up_data  = W'(5);
    up_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_up_ready", int'(up_ready), 0);
    end
    @(posedge clk);
    #1;
    down_ready = 1'b1;
    send_beat(5, 1'b1);
    @(negedge clk);
    check("refill_valid", int'(down_valid), 1);
    idle(2);

    // Randomized packets under random backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        send_beat($urandom_range(0, (1 << W) - 1) + MINV, b == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    down_ready = 1'b1;

    n = 0;
    while ((q.size() != 0 || down_valid) && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
    check("drain_valid_low", int'(down_valid), 0);
`ifdef SIGNED_SAT_ACC_CNT_EN
    check("sat_events_final", int'(sat_events), m_cnt);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
